// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage 1 registers bit and group propagate/generate; stage 2 resolves carries and registers the result and flags.
module cla_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic             ovf_sticky,
    input  logic             clr_ovf
);

    localparam int NB = WIDTH / BLOCK;

    // Handshake: a transfer happens on an edge where valid and ready are both 1.
    // Stage 2 advances when its slot is empty or being consumed; stage 1 advances
    // when empty or when stage 2 advances. in_ready depends only on registered state
    // and out_ready, never on in_valid.
    logic s1_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Operand transform and first-level propagate/generate
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;
    logic             c0_in;
    logic [NB-1:0]    bp_in;
    logic [NB-1:0]    bg_in;

    always_comb begin : blk_operand
        b_eff = op[0] ? ~b : b;
        c0_in = op[1] ? cin : op[0];
        p_in  = a ^ b_eff;
        g_in  = a & b_eff;
    end

    always_comb begin : blk_group
        logic gp;
        logic gg;
        gp    = 1'b0;
        gg    = 1'b0;
        bp_in = '0;
        bg_in = '0;
        for (int k = 0; k < NB; k++) begin
            gp = 1'b1;
            gg = 1'b0;
            for (int i = 0; i < BLOCK; i++) begin
                gg = g_in[k*BLOCK+i] | (p_in[k*BLOCK+i] & gg);
                gp = gp & p_in[k*BLOCK+i];
            end
            bp_in[k] = gp;
            bg_in[k] = gg;
        end
    end

    // Stage 1 registers
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [NB-1:0]    s1_bp;
    logic [NB-1:0]    s1_bg;
    logic             s1_c0;
    logic             s1_sat;
    logic             s1_a_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_bp    <= '0;
            s1_bg    <= '0;
            s1_c0    <= 1'b0;
            s1_sat   <= 1'b0;
            s1_a_msb <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_p     <= p_in;
                s1_g     <= g_in;
                s1_bp    <= bp_in;
                s1_bg    <= bg_in;
                s1_c0    <= c0_in;
                s1_sat   <= sat;
                s1_a_msb <= a[WIDTH-1];
            end
        end
    end

    // Second-level lookahead: each block carry is a flat sum of products of group terms.
    logic [NB:0] bc;

    always_comb begin : blk_block_carry
        logic acc;
        logic term;
        acc   = 1'b0;
        term  = 1'b0;
        bc    = '0;
        bc[0] = s1_c0;
        for (int k = 1; k <= NB; k++) begin
            acc = s1_c0;
            for (int j = 0; j < k; j++) acc = acc & s1_bp[j];
            for (int j = 0; j < k; j++) begin
                term = s1_bg[j];
                for (int m = j + 1; m < k; m++) term = term & s1_bp[m];
                acc = acc | term;
            end
            bc[k] = acc;
        end
    end

    // In-block lookahead from each block's incoming carry
    logic [WIDTH:0] c;

    always_comb begin : blk_bit_carry
        logic acc;
        logic term;
        acc  = 1'b0;
        term = 1'b0;
        c    = '0;
        for (int k = 0; k < NB; k++) begin
            c[k*BLOCK] = bc[k];
            for (int i = 1; i < BLOCK; i++) begin
                acc = bc[k];
                for (int j = 0; j < i; j++) acc = acc & s1_p[k*BLOCK+j];
                for (int j = 0; j < i; j++) begin
                    term = s1_g[k*BLOCK+j];
                    for (int m = j + 1; m < i; m++) term = term & s1_p[k*BLOCK+m];
                    acc = acc | term;
                end
                c[k*BLOCK+i] = acc;
            end
        end
        c[WIDTH] = bc[NB];
    end

    logic [WIDTH-1:0] raw_sum;
    logic             raw_ovf;
    logic [WIDTH-1:0] res_sum;

    assign raw_sum = s1_p ^ c[WIDTH-1:0];
    assign raw_ovf = c[WIDTH] ^ c[WIDTH-1];
    // Clamp toward the sign of a: positive overflow -> max, negative -> min
    assign res_sum = (s1_sat && raw_ovf) ? {s1_a_msb, {(WIDTH-1){~s1_a_msb}}} : raw_sum;

    // Stage 2 registers; data only changes when a valid result is loaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum   <= res_sum;
                c_out <= c[WIDTH];
                ovf   <= raw_ovf;
                zero  <= (res_sum == '0);
                neg   <= res_sum[WIDTH-1];
            end
        end
    end

    // Set has priority over clear so an overflow in the clearing cycle is not lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (s2_adv && s1_valid && raw_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule
